// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
// flash_loader: wakes a SPI flash, then copies LENGTH bytes into RAM while
// holding the CPU in reset.                                  Revision: 1.0
// ============================================================================
module flash_loader #(
   parameter int unsigned EEPROM_ADDRESS_BITS = 24,
   parameter logic [31:0] FLASH_BASE          = 'hE000,
   parameter logic [15:0] RAM_BASE            = 16'hE000,
   parameter int unsigned LENGTH              = 8192,
   parameter int unsigned TRES_CYCLES         = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        flash_sck,
   output logic        flash_cs_n,
   output logic        flash_si,
   input  logic        flash_so,
   output logic [15:0] ram_address,
   output logic [7:0]  ram_data,
   output logic        ram_we,
   output logic        cpu_reset_n,
   output logic        done
);

   localparam logic [2:0] c_release  = 3'd0;
   localparam logic [2:0] c_gap      = 3'd1;
   localparam logic [2:0] c_read_cmd = 3'd2;
   localparam logic [2:0] c_addr     = 3'd3;
   localparam logic [2:0] c_data     = 3'd4;
   localparam logic [2:0] c_done     = 3'd5;

   // Flash address left-aligned so every shift phase sends tx_q[31] first.
   localparam logic [31:0] c_addr_word = FLASH_BASE << (32 - EEPROM_ADDRESS_BITS);

   logic [2:0]  state_q, state_d;
   logic        cs_n_q, cs_n_d;
   logic        sck_q, sck_d;
   logic        si_q, si_d;
   logic        setup_q, setup_d;
   logic [31:0] tx_q, tx_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  rx_q, rx_d;
   logic [15:0] ram_address_q, ram_address_d;
   logic [7:0]  ram_data_q, ram_data_d;
   logic        ram_we_q, ram_we_d;
   logic        done_q, done_d;

   logic        bit_end;
   logic        last;

   assign bit_end = sck_q & ~setup_q;
   assign last    = (cnt_q == 32'd1);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= c_release;
         cs_n_q        <= 1'b1;
         sck_q         <= 1'b0;
         si_q          <= 1'b0;
         setup_q       <= 1'b0;
         tx_q          <= 32'd0;
         cnt_q         <= 32'd0;
         bit_q         <= 3'd0;
         rx_q          <= 8'd0;
         ram_address_q <= RAM_BASE;
         ram_data_q    <= 8'd0;
         ram_we_q      <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cs_n_q        <= cs_n_d;
         sck_q         <= sck_d;
         si_q          <= si_d;
         setup_q       <= setup_d;
         tx_q          <= tx_d;
         cnt_q         <= cnt_d;
         bit_q         <= bit_d;
         rx_q          <= rx_d;
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         ram_we_q      <= ram_we_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_release:  if (bit_end && last) state_d = c_gap;
         c_gap:      if (last) state_d = c_read_cmd;
         c_read_cmd: if (bit_end && last) state_d = c_addr;
         c_addr:     if (bit_end && last) state_d = c_data;
         c_data:     if (bit_end && bit_q == 3'd7 && last) state_d = c_done;
         c_done:     state_d = c_done;
         default:    state_d = c_release;
      endcase
   end

   always_comb begin
      cs_n_d        = cs_n_q;
      sck_d         = sck_q;
      si_d          = si_q;
      setup_d       = 1'b0;
      tx_d          = tx_q;
      cnt_d         = cnt_q;
      bit_d         = bit_q;
      rx_d          = rx_q;
      ram_address_d = ram_we_q ? ram_address_q + 16'd1 : ram_address_q;
      ram_data_d    = ram_data_q;
      ram_we_d      = 1'b0;
      done_d        = done_q;
      case (state_q)
         c_release, c_read_cmd, c_addr: begin
            if (state_q == c_release && cs_n_q) begin
               cs_n_d  = 1'b0;
               setup_d = 1'b1;
               tx_d    = {8'hAB, 24'd0};
               cnt_d   = 32'd8;
            end else if (bit_end && last) begin
               sck_d = 1'b0;
               if (state_q == c_release) begin
                  cs_n_d = 1'b1;
                  si_d   = 1'b0;
                  cnt_d  = 32'(TRES_CYCLES);
               end else if (state_q == c_read_cmd) begin
                  si_d  = c_addr_word[31];
                  tx_d  = c_addr_word << 1;
                  cnt_d = 32'(EEPROM_ADDRESS_BITS);
               end else begin
                  si_d  = 1'b0;
                  cnt_d = 32'(LENGTH);
                  bit_d = 3'd0;
               end
            end else if (setup_q || bit_end) begin
               // Start of a bit: SI changes only in the SCK-low phase.
               sck_d = 1'b0;
               si_d  = tx_q[31];
               tx_d  = tx_q << 1;
               if (bit_end) cnt_d = cnt_q - 32'd1;
            end else begin
               sck_d = 1'b1;
            end
         end
         c_gap: begin
            if (last) begin
               cs_n_d  = 1'b0;
               setup_d = 1'b1;
               tx_d    = {8'h03, 24'd0};
               cnt_d   = 32'd8;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         c_data: begin
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               sck_d = 1'b0;
               rx_d  = {rx_q[6:0], flash_so};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  ram_we_d   = 1'b1;
                  ram_data_d = {rx_q[6:0], flash_so};
                  cnt_d      = cnt_q - 32'd1;
                  if (last) begin
                     cs_n_d = 1'b1;
                     done_d = 1'b1;
                  end
               end
            end
         end
         c_done: begin
            cs_n_d = 1'b1;
            sck_d  = 1'b0;
            si_d   = 1'b0;
            done_d = 1'b1;
         end
         default: begin
            cs_n_d = 1'b1;
            sck_d  = 1'b0;
            si_d   = 1'b0;
         end
      endcase
   end

   assign flash_sck   = sck_q;
   assign flash_cs_n  = cs_n_q;
   assign flash_si    = si_q;
   assign ram_address = ram_address_q;
   assign ram_data    = ram_data_q;
   assign ram_we      = ram_we_q;
   assign done        = done_q;
   assign cpu_reset_n = done_q;

endmodule
`default_nettype wire
